mux_memoria_param: RTL and testbench
====================================

MUX_MEMORIA_PARAM -- requirements
Module: mux_memoria_param

Interface
REQ-001 Parameter WIDTH, default 2, data bits per channel.
REQ-002 Parameter NUM_CH, default 4, number of input channels (2..16).
REQ-003 Parameter SEL_W, default $clog2(NUM_CH), selector/channel-index width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset_L  input  1  reset is synchronous and active-low.
REQ-006 data_in  input  NUM_CH*WIDTH  packed channel data, channel i at bits [i*WIDTH +: WIDTH].
REQ-007 valid_in  input  NUM_CH  per-channel data-valid.
REQ-008 selector  input  SEL_W  channel select in fixed mode.
REQ-009 rr_mode  input  1  1 = round-robin arbitration, 0 = fixed selector.
REQ-010 ready_out  input  1  downstream accepts data_out this cycle.
REQ-011 data_out  output  WIDTH  registered (memory) output data.
REQ-012 valid_out  output  1  data_out holds an unconsumed word.
REQ-013 ch_out  output  SEL_W  index of channel that supplied data_out.
REQ-014 grant  output  NUM_CH  one-hot combinational: channel whose word is captured this cycle, else all-zero.

Function
REQ-015 Load condition: a candidate channel c exists AND (valid_out==0 OR ready_out==1).
REQ-016 Fixed mode: candidate is c=selector iff selector<NUM_CH and valid_in[selector]==1; selector>=NUM_CH yields no candidate.
REQ-017 Round-robin mode: candidate is first channel with valid_in set, searching rr_ptr, rr_ptr+1, ... wrapping modulo NUM_CH.
REQ-018 On load: data_out<=data_in[c], ch_out<=c, valid_out<=1, grant[c]=1 in that same cycle; latency input-to-output 1 cycle.
REQ-019 After a round-robin load, rr_ptr<=(c+1) mod NUM_CH; rr_ptr unchanged by fixed-mode loads and by non-load cycles.
REQ-020 No load with valid_out==1 and ready_out==1: valid_out<=0; data_out and ch_out hold last value.
REQ-021 No load with valid_out==1 and ready_out==0 (stall): all outputs hold; grant all-zero; no input consumed.
REQ-022 Consume and load in same cycle: new word replaces old, valid_out stays 1, no bubble.
REQ-023 data_out never changes except on load or reset (memory behaviour).
REQ-024 rr_mode toggling mid-operation takes effect next arbitration; rr_ptr retained.

Reset
REQ-025 While reset_L==0 at a clock edge: data_out<=0, valid_out<=0, ch_out<=0, rr_ptr<=0; reset overrides any load.
REQ-026 grant all-zero while reset_L==0.
REQ-027 First load possible on the first edge with reset_L==1.

Configuration
REQ-028 Macro MUX_MEMORIA_RR_EN defined: round-robin logic present, rr_mode honoured as REQ-017/019.
REQ-029 MUX_MEMORIA_RR_EN undefined: no rr_ptr register, rr_mode ignored, block always in fixed mode; port list identical.

Structure
REQ-030 Shared package mux_memoria_pkg holds MAX_CH=16 constant and the next-channel wrap function.
REQ-031 Sub-module rr_arbiter (NUM_CH request in, one-hot grant out, pointer register) is instantiated only under MUX_MEMORIA_RR_EN.

Verification
REQ-032 Reset: reset_L=0 two cycles with all valid_in=1 -> data_out=0, valid_out=0, ch_out=0, grant=0.
REQ-033 Fixed mode, WIDTH=2, selector=2, data_in ch2=2'b11, valid_in=4'b0100, ready_out=1 -> next cycle data_out=2'b11, ch_out=2, valid_out=1.
REQ-034 Stall: valid_out=1, ready_out=0, new valid on selected channel for 3 cycles -> data_out unchanged, grant=0 throughout.
REQ-035 Round-robin, valid_in=4'b1111, ready_out=1 constantly -> ch_out sequence 0,1,2,3,0; valid_out stays 1.
REQ-036 Round-robin wrap: rr_ptr=3, valid_in=4'b0011 -> ch_out=0, then 1; selector=5 in fixed mode with NUM_CH=4 -> no load, valid_out falls to 0 after consume, data_out holds.

Source files
------------

// File: rtl/mux_memoria_pkg.sv
// -----------------------------------------------------------------------------
// mux_memoria_pkg
// Shared constants and helpers for the mux_memoria_param channel multiplexer.
//   MAX_CH  : largest supported number of input channels.
//   next_ch : channel index following c, wrapping to 0 after n-1.
// -----------------------------------------------------------------------------
package mux_memoria_pkg;

    localparam int MAX_CH = 16;

    function automatic int next_ch(input int c, input int n);
        return (c + 1 >= n) ? 0 : c + 1;
    endfunction

endpackage : mux_memoria_pkg

// File: rtl/mux_memoria_param_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter with a rotating priority pointer. The first requester at
// or after the pointer (wrapping modulo NUM_CH) wins. The pointer moves just
// past the winner only when the caller consumes the grant.
// Only instantiated by mux_memoria_param when MUX_MEMORIA_RR_EN is defined.
//
// Ports:
//   clk        in   clock, rising edge
//   reset_L    in   synchronous active-low reset (pointer to 0)
//   i_req      in   NUM_CH request vector
//   i_advance  in   winner was consumed this cycle; advance the pointer
//   o_any      out  at least one request present
//   o_idx      out  index of the winning channel
//   o_grant    out  one-hot winner (all-zero when no request)
// -----------------------------------------------------------------------------
module rr_arbiter
    import mux_memoria_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic [NUM_CH-1:0] i_req,
    input  logic              i_advance,
    output logic              o_any,
    output logic [SEL_W-1:0]  o_idx,
    output logic [NUM_CH-1:0] o_grant
);

    logic [SEL_W-1:0]  r_ptr;
    logic              w_any;
    logic [SEL_W-1:0]  w_idx;
    logic [NUM_CH-1:0] w_grant;
    int                w_probe;

    // Scan distances 0..NUM_CH-1 from the pointer; the first requester wins.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so
        // no path leaves it unassigned, which would otherwise infer a latch.
        w_any   = 1'b0;
        w_idx   = '0;
        w_grant = '0;
        w_probe = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_probe = (int'(r_ptr) + k) % NUM_CH;
            for (int i = 0; i < NUM_CH; i++) begin
                if (!w_any && (i == w_probe) && i_req[i]) begin
                    w_any      = 1'b1;
                    w_idx      = SEL_W'(i);
                    w_grant[i] = 1'b1;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge; the reset branch is tested
    // inside the clocked block, making it synchronous.
    always_ff @(posedge clk) begin
        if (!reset_L) begin
            r_ptr <= '0;
        end else if (i_advance && w_any) begin
            r_ptr <= SEL_W'(next_ch(int'(w_idx), NUM_CH));
        end
    end

    assign o_any   = w_any;
    assign o_idx   = w_idx;
    assign o_grant = w_grant;

endmodule : rr_arbiter

// File: rtl/mux_memoria_param.sv
// -----------------------------------------------------------------------------
// mux_memoria_param
// Multiplexes NUM_CH data channels into a one-word output register with a
// valid/ready handshake. The output word is held (memory behaviour) until a
// new word is loaded. A word is loaded when a candidate channel exists and the
// register is empty or being consumed in the same cycle.
//
// Configuration macro MUX_MEMORIA_RR_EN:
//   defined   : rr_mode=1 selects round-robin arbitration over valid_in.
//   undefined : no round-robin logic; rr_mode is ignored, fixed selector only.
//
// Ports:
//   clk        in   clock, rising edge
//   reset_L    in   synchronous active-low reset
//   data_in    in   packed channel data, channel i at [i*WIDTH +: WIDTH]
//   valid_in   in   per-channel data valid
//   selector   in   channel index in fixed mode (>= NUM_CH selects nothing)
//   rr_mode    in   1 = round-robin, 0 = fixed selector
//   ready_out  in   downstream accepts data_out this cycle
//   data_out   out  registered output word
//   valid_out  out  data_out holds an unconsumed word
//   ch_out     out  channel that supplied data_out
//   grant      out  one-hot channel captured this cycle (combinational)
// -----------------------------------------------------------------------------
module mux_memoria_param
    import mux_memoria_pkg::*;
#(
    parameter int WIDTH  = 2,
    parameter int NUM_CH = 4,
    parameter int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    reset_L,
    input  logic [NUM_CH*WIDTH-1:0] data_in,
    input  logic [NUM_CH-1:0]       valid_in,
    input  logic [SEL_W-1:0]        selector,
    input  logic                    rr_mode,
    input  logic                    ready_out,
    output logic [WIDTH-1:0]        data_out,
    output logic                    valid_out,
    output logic [SEL_W-1:0]        ch_out,
    output logic [NUM_CH-1:0]       grant
);

    logic [WIDTH-1:0]  r_data;
    logic              r_valid;
    logic [SEL_W-1:0]  r_ch;

    logic              w_fix_valid;
    logic [SEL_W-1:0]  w_fix_idx;
    logic [NUM_CH-1:0] w_fix_onehot;

    logic              w_cand_valid;
    logic [SEL_W-1:0]  w_cand_idx;
    logic [NUM_CH-1:0] w_cand_onehot;
    logic [WIDTH-1:0]  w_cand_data;
    logic              w_load;

    // Fixed-mode candidate: a selector value outside 0..NUM_CH-1 matches no
    // channel and therefore yields no candidate.
    always_comb begin
        w_fix_valid  = 1'b0;
        w_fix_idx    = '0;
        w_fix_onehot = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if ((selector == SEL_W'(i)) && valid_in[i]) begin
                w_fix_valid     = 1'b1;
                w_fix_idx       = SEL_W'(i);
                w_fix_onehot[i] = 1'b1;
            end
        end
    end

`ifdef MUX_MEMORIA_RR_EN
    logic              w_rr_valid;
    logic [SEL_W-1:0]  w_rr_idx;
    logic [NUM_CH-1:0] w_rr_onehot;

    // The pointer only advances on a load taken in round-robin mode, so it is
    // retained across fixed-mode periods and stalls.
    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_rr_arbiter (
        .clk       (clk),
        .reset_L   (reset_L),
        .i_req     (valid_in),
        .i_advance (w_load && rr_mode),
        .o_any     (w_rr_valid),
        .o_idx     (w_rr_idx),
        .o_grant   (w_rr_onehot)
    );

    assign w_cand_valid  = rr_mode ? w_rr_valid  : w_fix_valid;
    assign w_cand_idx    = rr_mode ? w_rr_idx    : w_fix_idx;
    assign w_cand_onehot = rr_mode ? w_rr_onehot : w_fix_onehot;
`else
    logic w_unused_rr_mode;

    assign w_unused_rr_mode = rr_mode;
    assign w_cand_valid     = w_fix_valid;
    assign w_cand_idx       = w_fix_idx;
    assign w_cand_onehot    = w_fix_onehot;
`endif

    always_comb begin
        w_cand_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_cand_idx == SEL_W'(i)) begin
                w_cand_data = data_in[i*WIDTH +: WIDTH];
            end
        end
    end

    // Load when the output register is free or drained this same cycle;
    // reset suppresses any load and forces grant to zero.
    assign w_load = reset_L && w_cand_valid && (!r_valid || ready_out);
    assign grant  = w_load ? w_cand_onehot : '0;

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ch    <= '0;
        end else if (w_load) begin
            r_data  <= w_cand_data;
            r_valid <= 1'b1;
            r_ch    <= w_cand_idx;
        end else if (ready_out) begin
            // Consumed with nothing to replace it: word stays, valid drops.
            r_valid <= 1'b0;
        end
    end

    assign data_out  = r_data;
    assign valid_out = r_valid;
    assign ch_out    = r_ch;

endmodule : mux_memoria_param

// File: tb/tb_mux_memoria_param.sv
// -----------------------------------------------------------------------------
// tb_mux_memoria_param
// Directed bench for mux_memoria_param (WIDTH=2, NUM_CH=4, SEL_W=3 so that an
// out-of-range selector can be driven). Each step drives inputs, checks the
// combinational grant before the edge, then checks the registered outputs
// just after the edge. Expected values are hand-computed.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mux_memoria_param;

    localparam int WIDTH  = 2;
    localparam int NUM_CH = 4;
    localparam int SEL_W  = 3;

    logic                    clk;
    logic                    reset_L;
    logic [NUM_CH*WIDTH-1:0] data_in;
    logic [NUM_CH-1:0]       valid_in;
    logic [SEL_W-1:0]        selector;
    logic                    rr_mode;
    logic                    ready_out;
    logic [WIDTH-1:0]        data_out;
    logic                    valid_out;
    logic [SEL_W-1:0]        ch_out;
    logic [NUM_CH-1:0]       grant;

    mux_memoria_param #(
        .WIDTH  (WIDTH),
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) dut (
        .clk       (clk),
        .reset_L   (reset_L),
        .data_in   (data_in),
        .valid_in  (valid_in),
        .selector  (selector),
        .rr_mode   (rr_mode),
        .ready_out (ready_out),
        .data_out  (data_out),
        .valid_out (valid_out),
        .ch_out    (ch_out),
        .grant     (grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       rr;
        logic [2:0] sel;
        logic [3:0] vin;
        logic [7:0] din;
        logic       rdy;
        logic [3:0] e_grant;
        logic       e_valid;
        logic [1:0] e_data;
        logic [2:0] e_ch;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp  = 0;
    int   n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic rr, input logic [2:0] sel,
                       input logic [3:0] vin, input logic [7:0] din, input logic rdy,
                       input logic [3:0] eg, input logic ev, input logic [1:0] ed,
                       input logic [2:0] ech);
        vec_t v;
        v.rst = rst; v.rr = rr; v.sel = sel; v.vin = vin; v.din = din; v.rdy = rdy;
        v.e_grant = eg; v.e_valid = ev; v.e_data = ed; v.e_ch = ech;
        vecs.push_back(v);
    endtask

    // Drive one step, check grant before the edge and registered outputs after.
    task automatic run_step(input string tag, input vec_t v);
        reset_L   = v.rst;
        rr_mode   = v.rr;
        selector  = v.sel;
        valid_in  = v.vin;
        data_in   = v.din;
        ready_out = v.rdy;
        #1;
        check({tag, ".grant"}, 32'(grant), 32'(v.e_grant));
        @(posedge clk);
        #1;
        check({tag, ".valid_out"}, 32'(valid_out), 32'(v.e_valid));
        check({tag, ".data_out"},  32'(data_out),  32'(v.e_data));
        check({tag, ".ch_out"},    32'(ch_out),    32'(v.e_ch));
    endtask

    initial begin
        reset_L = 1'b0; rr_mode = 1'b0; selector = '0;
        valid_in = '0; data_in = '0; ready_out = 1'b0;

        //   rst rr sel vin      din    rdy grant    v  data   ch
        add(0, 0, 0, 4'b1111, 8'hFF, 1, 4'b0000, 0, 2'd0, 3'd0); // reset, all valid
        add(0, 0, 0, 4'b1111, 8'hFF, 1, 4'b0000, 0, 2'd0, 3'd0); // reset 2nd cycle
        add(1, 0, 2, 4'b0100, 8'h30, 1, 4'b0100, 1, 2'd3, 3'd2); // fixed ch2 = 11
        add(1, 0, 2, 4'b0100, 8'h10, 0, 4'b0000, 1, 2'd3, 3'd2); // stall 1
        add(1, 0, 2, 4'b0100, 8'h10, 0, 4'b0000, 1, 2'd3, 3'd2); // stall 2
        add(1, 0, 2, 4'b0100, 8'h10, 0, 4'b0000, 1, 2'd3, 3'd2); // stall 3
        add(1, 0, 2, 4'b0100, 8'h10, 1, 4'b0100, 1, 2'd1, 3'd2); // consume + load
        add(1, 0, 0, 4'b0001, 8'h02, 1, 4'b0001, 1, 2'd2, 3'd0); // fixed ch0
        add(1, 0, 1, 4'b0001, 8'h02, 1, 4'b0000, 0, 2'd2, 3'd0); // selected ch idle
        add(1, 0, 1, 4'b0010, 8'h0C, 0, 4'b0010, 1, 2'd3, 3'd1); // empty: load w/o ready
        add(1, 0, 5, 4'b1111, 8'h00, 1, 4'b0000, 0, 2'd3, 3'd1); // selector out of range
        add(1, 0, 5, 4'b1111, 8'h00, 1, 4'b0000, 0, 2'd3, 3'd1); // still no load
        add(1, 0, 3, 4'b1000, 8'h40, 0, 4'b1000, 1, 2'd1, 3'd3); // fixed ch3
        add(0, 0, 3, 4'b1000, 8'hC0, 1, 4'b0000, 0, 2'd0, 3'd0); // reset beats load
        add(1, 0, 0, 4'b0001, 8'h01, 0, 4'b0001, 1, 2'd1, 3'd0); // first edge out of reset

        for (int i = 0; i < vecs.size(); i++) begin
            run_step($sformatf("vec%0d", i), vecs[i]);
        end
        vecs.delete();

`ifdef MUX_MEMORIA_RR_EN
        // Round-robin: pointer starts at 0 after reset; ch i carries value i.
        add(1, 1, 0, 4'b1111, 8'hE4, 1, 4'b0001, 1, 2'd0, 3'd0);
        add(1, 1, 0, 4'b1111, 8'hE4, 1, 4'b0010, 1, 2'd1, 3'd1);
        add(1, 1, 0, 4'b1111, 8'hE4, 1, 4'b0100, 1, 2'd2, 3'd2);
        add(1, 1, 0, 4'b1111, 8'hE4, 1, 4'b1000, 1, 2'd3, 3'd3);
        add(1, 1, 0, 4'b1111, 8'hE4, 1, 4'b0001, 1, 2'd0, 3'd0); // wraps, ptr -> 1
        add(1, 1, 0, 4'b0100, 8'hE4, 1, 4'b0100, 1, 2'd2, 3'd2); // ptr -> 3
        add(1, 1, 0, 4'b0011, 8'hE4, 1, 4'b0001, 1, 2'd0, 3'd0); // wrap from 3 to 0
        add(1, 1, 0, 4'b0011, 8'hE4, 1, 4'b0010, 1, 2'd1, 3'd1); // ptr -> 2
        add(1, 0, 3, 4'b1000, 8'hE4, 1, 4'b1000, 1, 2'd3, 3'd3); // fixed, ptr kept at 2
        add(1, 1, 0, 4'b1111, 8'hE4, 1, 4'b0100, 1, 2'd2, 3'd2); // resumes at 2, ptr -> 3
        add(1, 1, 0, 4'b0000, 8'hE4, 1, 4'b0000, 0, 2'd2, 3'd2); // drain, data holds
        add(1, 1, 0, 4'b1111, 8'hE4, 0, 4'b1000, 1, 2'd3, 3'd3); // empty: load ch3, ptr -> 0
        add(1, 1, 0, 4'b1111, 8'hE4, 0, 4'b0000, 1, 2'd3, 3'd3); // stall, ptr stays 0
        add(1, 1, 0, 4'b1111, 8'hE4, 1, 4'b0001, 1, 2'd0, 3'd0); // continues at 0
        for (int i = 0; i < vecs.size(); i++) begin
            run_step($sformatf("rr%0d", i), vecs[i]);
        end
`else
        // Without round-robin support rr_mode is ignored: selector still rules.
        add(1, 1, 1, 4'b1111, 8'hE4, 1, 4'b0010, 1, 2'd1, 3'd1);
        add(1, 1, 1, 4'b1111, 8'hE4, 1, 4'b0010, 1, 2'd1, 3'd1);
        add(1, 1, 1, 4'b1111, 8'hE4, 1, 4'b0010, 1, 2'd1, 3'd1);
        add(1, 1, 0, 4'b1111, 8'hE4, 1, 4'b0001, 1, 2'd0, 3'd0);
        add(1, 1, 5, 4'b1111, 8'hE4, 1, 4'b0000, 0, 2'd0, 3'd0);
        for (int i = 0; i < vecs.size(); i++) begin
            run_step($sformatf("fx%0d", i), vecs[i]);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_mux_memoria_param
